// File: rtl/sr_ff_cmd_arbiter_if.sv
// Requester-side bundle of the SR-flop command arbiter: requests, ops, grant and completion status.
interface sr_ff_cmd_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] op_set;
  logic [NUM_REQ-1:0] gnt;
  logic               ack;
  logic               err;
  logic               busy;

  modport master (output req, output op_set, input gnt, input ack, input err, input busy);
  modport slave  (input req, input op_set, output gnt, output ack, output err, output busy);
endinterface

// File: rtl/sr_ff_cmd_arbiter.sv
// Round-robin arbiter sequencing set/clear commands from NUM_REQ requesters onto one SR flop.
// Optional SR_FF_CMD_ARBITER_SKIP_REDUNDANT_EN: skip the s/r pulse when Q already holds the requested value.
module sr_ff_cmd_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  sr_ff_cmd_arbiter_if.slave  bus,
  output logic                s,
  output logic                r,
  input  logic                q_in
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic               r_skip;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_ack;
  logic               r_err;
  logic               r_s;
  logic               r_r;
  logic               r_busy;

  logic [PTR_W-1:0]   w_win;
  logic               w_found;

  // First active request scanning upward from the round-robin pointer, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req[PTR_W'((32'(r_ptr) + i) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_win   = PTR_W'((32'(r_ptr) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_skip  <= 1'b0;
      r_gnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          r_s   <= 1'b0;
          r_r   <= 1'b0;
          if (w_found) begin
            r_win   <= w_win;
            r_op    <= bus.op_set[w_win];
            r_gnt   <= NUM_REQ'(1) << w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= DRIVE;
`ifdef SR_FF_CMD_ARBITER_SKIP_REDUNDANT_EN
            if (bus.op_set[w_win] == q_in) begin
              r_skip <= 1'b1;
            end else begin
              r_skip <= 1'b0;
              r_s    <= bus.op_set[w_win];
              r_r    <= ~bus.op_set[w_win];
            end
`else
            r_skip <= 1'b0;
            r_s    <= bus.op_set[w_win];
            r_r    <= ~bus.op_set[w_win];
`endif
          end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        // Hold s/r for HOLD_CYC cycles; ack/err register on the edge entering CHECK.
        DRIVE: begin
          if (r_skip || (r_cnt == CNT_W'(HOLD_CYC - 1))) begin
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_ack   <= 1'b1;
            r_err   <= (q_in != r_op);
            r_skip  <= 1'b0;
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= ((32'(r_win) + 32'd1) == NUM_REQ) ? '0 : r_win + PTR_W'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.ack  = r_ack;
  assign bus.err  = r_err;
  assign bus.busy = r_busy;
  assign s        = r_s;
  assign r        = r_r;
endmodule

// File: tb/tb_sr_ff_cmd_arbiter.sv
// Directed bench for sr_ff_cmd_arbiter with an SR flop model and an ack scoreboard.
module tb_sr_ff_cmd_arbiter;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned HOLD_CYC = 2;

  typedef struct {
    int   idx;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic s, r, q_in;
  logic q_model;
  logic stuck;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  sr_ff_cmd_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  sr_ff_cmd_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_CYC(HOLD_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .s     (s),
    .r     (r),
    .q_in  (q_in)
  );

  always #5 clk = ~clk;

  // SR flop model, Q cleared by reset; stuck forces the feedback to 0.
  always @(posedge clk) begin
    if (reset)  q_model <= 1'b0;
    else if (s) q_model <= 1'b1;
    else if (r) q_model <= 1'b0;
  end
  assign q_in = stuck ? 1'b0 : q_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Invariants every cycle, scoreboard pop on every ack.
  always @(negedge clk) begin
    if (!reset) begin
      chk("s_r_exclusive", 32'(s & r), 0);
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
      chk("err_without_ack", 32'(bus.err & ~bus.ack), 0);
      if (bus.ack === 1'b1) begin
        chk("sb_pending", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_gnt", 32'(bus.gnt), 32'(1) << e.idx);
          chk("sb_err", 32'(bus.err), 32'(e.err));
        end
      end
    end
  end

  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (bus.ack !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("ack_timeout", 32'(bus.ack), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One command from an idle arbiter: req seen at edge T, checks through T+4.
  task automatic run_single(input int idx, input logic op, input logic exp_err);
    logic [NUM_REQ-1:0] v;
    v = NUM_REQ'(1) << idx;
    bus.req    = v;
    bus.op_set = op ? v : '0;
    sb.push_back('{idx, exp_err});
    @(negedge clk);
    chk("gnt_T1", 32'(bus.gnt), 32'(v));
    chk("s_T1", 32'(s), 32'(op));
    chk("r_T1", 32'(r), 32'(!op));
    chk("busy_T1", 32'(bus.busy), 1);
    @(negedge clk);
    chk("s_T2", 32'(s), 32'(op));
    chk("r_T2", 32'(r), 32'(!op));
    @(negedge clk);
    chk("ack_T3", 32'(bus.ack), 1);
    chk("err_T3", 32'(bus.err), 32'(exp_err));
    chk("sr_off_T3", 32'({s, r}), 0);
    if (!stuck) chk("q_T3", 32'(q_in), 32'(op));
    bus.req    = '0;
    bus.op_set = '0;
    @(negedge clk);
    chk("gnt_clr_T4", 32'(bus.gnt), 0);
    chk("ack_clr_T4", 32'(bus.ack), 0);
    chk("busy_clr_T4", 32'(bus.busy), 0);
  endtask

  initial begin
    int cyc;
    int order[5];
    order      = '{0, 1, 2, 3, 0};
    stuck      = 1'b0;
    bus.req    = '0;
    bus.op_set = '0;

    // Reset then quiet idle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({bus.gnt, s, r, bus.ack, bus.err, bus.busy}), 0);
    end

    // Single requester set, then clear.
    run_single(0, 1'b1, 1'b0);
    run_single(0, 1'b0, 1'b0);

    // Stuck-at-0 feedback on a set reports err, next command proceeds normally.
    stuck = 1'b1;
    run_single(2, 1'b1, 1'b1);
    stuck = 1'b0;
    run_single(1, 1'b1, 1'b0);

    // Requester drops req and flips op after grant: original command completes.
    run_single(0, 1'b0, 1'b0);
    bus.req    = 4'b1000;
    bus.op_set = 4'b1000;
    sb.push_back('{3, 1'b0});
    @(negedge clk);
    chk("drop_gnt", 32'(bus.gnt), 32'h8);
    bus.req    = '0;
    bus.op_set = '0;
    @(negedge clk);
    chk("drop_s_hold", 32'(s), 1);
    @(negedge clk);
    chk("drop_ack", 32'(bus.ack), 1);
    chk("drop_q", 32'(q_in), 1);
    @(negedge clk);
    chk("drop_gnt_clr", 32'(bus.gnt), 0);

    // Full contention from a fresh pointer.
    do_reset();
    bus.req    = 4'b1111;
    bus.op_set = 4'b0101;
    for (int k = 0; k < 5; k++) sb.push_back('{order[k], 1'b0});
    for (int k = 0; k < 5; k++) begin
      wait_ack(cyc);
      chk("rr_order", 32'(bus.gnt), 32'(1) << order[k]);
      if (k > 0) chk("ack_spacing", 32'(cyc + 1), 32'(HOLD_CYC + 2));
      if (k == 4) bus.req = '0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("contention_idle", 32'(bus.busy), 0);

    // Reset during DRIVE: no ack, pointer returns to 0.
    run_single(2, 1'b1, 1'b0);
    bus.req    = 4'b0010;
    bus.op_set = 4'b0010;
    @(negedge clk);
    chk("mid_gnt", 32'(bus.gnt), 32'h2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_outputs", 32'({bus.gnt, s, r, bus.ack, bus.busy}), 0);
    reset      = 1'b0;
    bus.req    = '0;
    bus.op_set = '0;
    repeat (2) @(negedge clk);
    chk("mid_no_ack", 32'(bus.ack), 0);
    bus.req    = 4'b0110;
    bus.op_set = 4'b0110;
    sb.push_back('{1, 1'b0});
    sb.push_back('{2, 1'b0});
    wait_ack(cyc);
    chk("ptr0_first", 32'(bus.gnt), 32'h2);
    @(negedge clk);
    wait_ack(cyc);
    chk("ptr0_second", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("final_busy", 32'(bus.busy), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end
endmodule
